// File: rtl/cmdout_queue_scanner_if.sv
// cmdout_queue_scanner_if: the BRAM port and entry stream that connect cmdout_queue_scanner to the memory and the stream sink
interface cmdout_queue_scanner_if #(
    parameter int MAX_ACCS = 16
);
    logic                        cmdout_queue_en;
    logic [7:0]                  cmdout_queue_we;
    logic [31:0]                 cmdout_queue_addr;
    logic [63:0]                 cmdout_queue_din;
    logic [63:0]                 cmdout_queue_dout;
    logic                        out_tvalid;
    logic                        out_tready;
    logic [$clog2(MAX_ACCS)-1:0] out_tdest;
    logic [63:0]                 out_tdata;
    logic                        out_tlast;

    modport master (
        output cmdout_queue_en, cmdout_queue_we, cmdout_queue_addr, cmdout_queue_din,
        input  cmdout_queue_dout,
        output out_tvalid, out_tdest, out_tdata, out_tlast,
        input  out_tready
    );

    modport slave (
        input  cmdout_queue_en, cmdout_queue_we, cmdout_queue_addr, cmdout_queue_din,
        output cmdout_queue_dout,
        input  out_tvalid, out_tdest, out_tdata, out_tlast,
        output out_tready
    );
endinterface

// File: rtl/cmdout_queue_scanner.sv
// cmdout_queue_scanner: round-robin scan of per-accelerator cmdout subqueues in BRAM, forwarding each valid word (bit 63 set) to the stream and clearing it
// Optional feature: define CMDOUT_SCANNER_STATS_EN to count forwarded entries on stat_forwarded (saturating); otherwise it is tied to 0.
module cmdout_queue_scanner #(
    parameter int MAX_ACCS            = 16,
    parameter int CMDOUT_SUBQUEUE_LEN = 64
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   enable,
    cmdout_queue_scanner_if.master bus,
    output logic [31:0]            stat_forwarded
);
    localparam int AW = $clog2(MAX_ACCS);
    localparam int PW = $clog2(CMDOUT_SUBQUEUE_LEN);

    typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, CLEAR} state_t;

    state_t        state;
    logic [AW-1:0] acc;
    logic [PW-1:0] ptr [MAX_ACCS];
    logic          en;
    logic [7:0]    we;
    logic [31:0]   addr;
    logic          tvalid;
    logic          tlast;
    logic [AW-1:0] tdest;
    logic [63:0]   tdata;
    logic [AW-1:0] acc_next;
    logic [PW-1:0] ptr_next;

    // Word idx of subqueue a lives at byte address (a*LEN + idx)*8; LEN is a power of two so this is a concatenation
    function automatic logic [31:0] word_addr(input logic [AW-1:0] a, input logic [PW-1:0] p);
        return 32'({a, p, 3'b000});
    endfunction

    // Next subqueue in round-robin order and the pointer it will have once a CLEAR bump lands
    always_comb begin
        acc_next = (acc == AW'(MAX_ACCS - 1)) ? '0 : acc + 1'b1;
        ptr_next = (state == CLEAR && acc_next == acc) ? ptr[acc] + 1'b1 : ptr[acc_next];
    end

    // Scanner FSM; BRAM and stream outputs are registered alongside the state they belong to
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state  <= IDLE;
            acc    <= '0;
            for (int i = 0; i < MAX_ACCS; i++) ptr[i] <= '0;
            en     <= 1'b0;
            we     <= '0;
            addr   <= '0;
            tvalid <= 1'b0;
            tdata  <= '0;
            tdest  <= '0;
            tlast  <= 1'b0;
        end else begin
            en   <= 1'b0;
            we   <= '0;
            addr <= '0;
            case (state)
                IDLE: if (enable) begin
                    state <= READ;
                    en    <= 1'b1;
                    addr  <= word_addr(acc, ptr[acc]);
                end
                READ: state <= WAIT;
                WAIT: if (bus.cmdout_queue_dout[63]) begin
                    state  <= SEND;
                    tvalid <= 1'b1;
                    tdata  <= bus.cmdout_queue_dout;
                    tdest  <= acc;
                    tlast  <= 1'b1;
                end else begin
                    acc <= acc_next;
                    if (enable) begin
                        state <= READ;
                        en    <= 1'b1;
                        addr  <= word_addr(acc_next, ptr[acc_next]);
                    end else begin
                        state <= IDLE;
                    end
                end
                SEND: if (bus.out_tready) begin
                    state  <= CLEAR;
                    tvalid <= 1'b0;
                    tlast  <= 1'b0;
                    en     <= 1'b1;
                    we     <= 8'hFF;
                    addr   <= word_addr(acc, ptr[acc]);
                end
                CLEAR: begin
                    ptr[acc] <= ptr[acc] + 1'b1;
                    acc      <= acc_next;
                    if (enable) begin
                        state <= READ;
                        en    <= 1'b1;
                        addr  <= word_addr(acc_next, ptr_next);
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CMDOUT_SCANNER_STATS_EN
    // Saturating count of completed stream handshakes
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) stat_forwarded <= '0;
        else if (tvalid && bus.out_tready && stat_forwarded != '1) stat_forwarded <= stat_forwarded + 1'b1;
    end
`else
    assign stat_forwarded = '0;
`endif

    assign bus.cmdout_queue_en   = en;
    assign bus.cmdout_queue_we   = we;
    assign bus.cmdout_queue_addr = addr;
    assign bus.cmdout_queue_din  = '0;
    assign bus.out_tvalid        = tvalid;
    assign bus.out_tdata         = tdata;
    assign bus.out_tdest         = tdest;
    assign bus.out_tlast         = tlast;
endmodule

// File: doc/cmdout_queue_scanner.md
CMDOUT_QUEUE_SCANNER -- requirements
Module: cmdout_queue_scanner

Interface
REQ-001 SHALL have parameter MAX_ACCS, default 16, giving the number of accelerator subqueues.
REQ-002 SHALL have parameter CMDOUT_SUBQUEUE_LEN, default 64, giving 64-bit words per subqueue (power of two).
REQ-003 SHALL have port aclk, input, 1 bit: the single clock; all logic rising-edge.
REQ-004 SHALL have port aresetn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port enable, input, 1 bit: scanning permitted while high.
REQ-006 SHALL have port cmdout_queue_en, output, 1 bit: BRAM port enable.
REQ-007 SHALL have port cmdout_queue_we, output, 8 bits: BRAM byte write enables.
REQ-008 SHALL have port cmdout_queue_addr, output, 32 bits: BRAM byte address.
REQ-009 SHALL have port cmdout_queue_din, output, 64 bits: BRAM write data.
REQ-010 SHALL have port cmdout_queue_dout, input, 64 bits: BRAM read data, 1-cycle latency.
REQ-011 SHALL have ports out_tvalid (output, 1), out_tready (input, 1), out_tdest (output, $clog2(MAX_ACCS)), out_tdata (output, 64) and out_tlast (output, 1): the entry stream.
REQ-012 SHALL have port stat_forwarded, output, 32 bits: count of forwarded entries.

Function
REQ-013 SHALL map word idx of subqueue a to byte address (a*CMDOUT_SUBQUEUE_LEN + idx)*8.
REQ-014 SHALL treat a word as valid when bit 63 is 1.
REQ-015 SHALL keep one read pointer per subqueue, width $clog2(CMDOUT_SUBQUEUE_LEN), wrapping from LEN-1 to 0.
REQ-016 SHALL use FSM states IDLE, READ, WAIT, SEND and CLEAR.
REQ-017 IDLE->READ when enable=1; otherwise SHALL stay in IDLE.
REQ-018 READ: SHALL assert en=1, we=0 and addr of the current subqueue/pointer for one cycle, then go to WAIT.
REQ-019 WAIT: SHALL sample dout; if valid, SHALL register it and go to SEND; else SHALL advance the subqueue index (round-robin, MAX_ACCS-1 wraps to 0) and go to READ, or to IDLE if enable=0.
REQ-020 SHALL therefore inspect an empty slot in 2 cycles.
REQ-021 SEND: SHALL drive out_tvalid=1, out_tdata=registered word, out_tdest=subqueue index and out_tlast=1, all held stable until out_tready=1; the cycle after the handshake SHALL be CLEAR.
REQ-022 SHALL not drop out_tvalid in SEND for any reason except reset; enable=0 SHALL be honoured only after CLEAR.
REQ-023 CLEAR: SHALL write 64'h0 (en=1, we=8'hFF) to the same address, increment that subqueue's pointer, advance the subqueue index, then go to READ (or IDLE if enable=0).
REQ-024 SHALL serve at most one entry per subqueue visit, so no subqueue starves another.
REQ-025 SHALL drive en=0, we=0 and addr=0 outside READ and CLEAR.
REQ-026 SHALL drive din=0 in every state.
REQ-027 SHALL keep out_tvalid=0 outside SEND.

Reset
REQ-028 aresetn=0 SHALL immediately force state IDLE, all pointers 0, subqueue index 0, out_tvalid=0, out_tdata=0, out_tdest=0, out_tlast=0, en=0, we=0, addr=0 and stat_forwarded=0.
REQ-029 Reset during SEND SHALL abandon the entry uncleared, so it is re-delivered after reset if memory was not re-initialised.

Configuration
REQ-030 With macro CMDOUT_SCANNER_STATS_EN defined, stat_forwarded SHALL increment by 1 on each out handshake, saturating at 32'hFFFFFFFF.
REQ-031 Without CMDOUT_SCANNER_STATS_EN, stat_forwarded SHALL be constant 0 and no counter register SHALL exist.

Verification
REQ-032 All memory words zero, enable=1 -> addresses 0x0, 0x200, 0x400 ... read every 2 cycles, wrapping to 0x0 after subqueue 15; out_tvalid never asserted.
REQ-033 Word 0x8000_0000_0000_00AB at subqueue 3 idx 0 -> out_tdata=0x8000_0000_0000_00AB, tdest=3, tlast=1; next cycle write of 0 to 0x600 with we=0xFF; subqueue 3 pointer becomes 1.
REQ-034 Valid entries at subqueues 2 and 5, out_tready held 0 for 10 cycles -> tvalid/tdata/tdest stable for 10 cycles; subqueue 2 delivered first, subqueue 5 delivered second.
REQ-035 Subqueue 0 pointer at 63 with valid word at address 0x1F8 -> after forwarding, next read of subqueue 0 is at address 0x0.
REQ-036 aresetn pulsed low during SEND -> tvalid=0 the same cycle; after release, the same entry is re-delivered from pointer 0.
REQ-037 With CMDOUT_SCANNER_STATS_EN, 5 forwarded entries -> stat_forwarded=5; without the macro -> stat_forwarded=0.
